// File: rtl/rip_mem_port_arbiter_if.sv
// Simple command port of rip_axi_master: one write channel and one read channel,
// each with a valid/ready command handshake and a one-cycle done pulse.
interface rip_mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
);
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [LINE_SIZE*8-1:0] wdata;
    logic [LINE_SIZE-1:0]   wstrb;
    logic                   wvalid;
    logic                   wready;
    logic                   wdone;
    logic [ADDR_WIDTH-1:0]  raddr;
    logic                   rvalid;
    logic                   rready;
    logic                   rdone;
    logic [LINE_SIZE*8-1:0] rdata;

    modport master (
        output waddr, wdata, wstrb, wvalid, raddr, rvalid,
        input  wready, wdone, rready, rdone, rdata
    );

    modport slave (
        input  waddr, wdata, wstrb, wvalid, raddr, rvalid,
        output wready, wdone, rready, rdone, rdata
    );
endinterface

// File: rtl/rip_mem_port_arbiter.sv
// Two-client arbiter in front of the rip_axi_master command port; one transaction in flight,
// round-robin grant, or fixed client-0 priority when RIP_MEM_ARB_FIXED_PRIO_EN is defined.
module rip_mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              c0_req,
    input  logic [LINE_SIZE-1:0]              c0_we,
    input  logic [ADDR_WIDTH-1:0]             c0_addr,
    input  logic [LINE_SIZE*8-1:0]            c0_wdata,
    output logic [LINE_SIZE*8-1:0]            c0_rdata,
    output logic                              c0_done,
    input  logic                              c1_req,
    input  logic [LINE_SIZE-1:0]              c1_we,
    input  logic [ADDR_WIDTH-1:0]             c1_addr,
    input  logic [LINE_SIZE*8-1:0]            c1_wdata,
    output logic [LINE_SIZE*8-1:0]            c1_rdata,
    output logic                              c1_done,
    rip_mem_port_arbiter_if.master            mst
);
    localparam int B_WIDTH = 8;
    localparam int DATA_W  = LINE_SIZE * B_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   gnt;
    logic                   is_wr;
    logic                   pick1;
    logic [LINE_SIZE-1:0]   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic [ADDR_WIDTH-1:0]  waddr_q, raddr_q;
    logic [DATA_W-1:0]      wdata_q, c0_rdata_q, c1_rdata_q;
    logic [LINE_SIZE-1:0]   wstrb_q;
    logic                   wvalid_q, rvalid_q, c0_done_q, c1_done_q;
`ifndef RIP_MEM_ARB_FIXED_PRIO_EN
    logic                   last_grant;
`endif

    // Grant selection: client 1 only wins when it is alone or it is client 1's turn.
    always_comb begin
`ifdef RIP_MEM_ARB_FIXED_PRIO_EN
        pick1 = c1_req && !c0_req;
`else
        pick1 = c1_req && (!c0_req || !last_grant);
`endif
        sel_we    = pick1 ? c1_we    : c0_we;
        sel_addr  = pick1 ? c1_addr  : c0_addr;
        sel_wdata = pick1 ? c1_wdata : c0_wdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (c0_req || c1_req) state_nxt = ISSUE;
            ISSUE: if (is_wr ? (wvalid_q && mst.wready) : (rvalid_q && mst.rready)) state_nxt = WAIT;
            WAIT:  if (is_wr ? mst.wdone : mst.rdone) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            is_wr      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wvalid_q   <= 1'b0;
            raddr_q    <= '0;
            rvalid_q   <= 1'b0;
            c0_rdata_q <= '0;
            c1_rdata_q <= '0;
            c0_done_q  <= 1'b0;
            c1_done_q  <= 1'b0;
`ifndef RIP_MEM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (c0_req || c1_req) begin
                    gnt   <= pick1;
                    is_wr <= |sel_we;
`ifndef RIP_MEM_ARB_FIXED_PRIO_EN
                    last_grant <= pick1;
`endif
                    if (|sel_we) begin
                        waddr_q  <= sel_addr;
                        wdata_q  <= sel_wdata;
                        wstrb_q  <= sel_we;
                        wvalid_q <= 1'b1;
                    end else begin
                        raddr_q  <= sel_addr;
                        rvalid_q <= 1'b1;
                    end
                end
                // Only one valid is ever high here, so clearing both on their ready is safe.
                ISSUE: begin
                    if (mst.wready) wvalid_q <= 1'b0;
                    if (mst.rready) rvalid_q <= 1'b0;
                end
                WAIT: if (is_wr ? mst.wdone : mst.rdone) begin
                    if (!is_wr) begin
                        if (gnt) c1_rdata_q <= mst.rdata;
                        else     c0_rdata_q <= mst.rdata;
                    end
                    if (gnt) c1_done_q <= 1'b1;
                    else     c0_done_q <= 1'b1;
                end
                RESP: begin
                    c0_done_q <= 1'b0;
                    c1_done_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mst.waddr  = waddr_q;
    assign mst.wdata  = wdata_q;
    assign mst.wstrb  = wstrb_q;
    assign mst.wvalid = wvalid_q;
    assign mst.raddr  = raddr_q;
    assign mst.rvalid = rvalid_q;
    assign c0_rdata   = c0_rdata_q;
    assign c1_rdata   = c1_rdata_q;
    assign c0_done    = c0_done_q;
    assign c1_done    = c1_done_q;
endmodule

// File: tb/tb_rip_mem_port_arbiter.sv
// Directed bench for rip_mem_port_arbiter; the arbitration scenario follows RIP_MEM_ARB_FIXED_PRIO_EN.
module tb_rip_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        c0_req, c1_req;
    logic [3:0]  c0_we, c1_we;
    logic [31:0] c0_addr, c1_addr, c0_wdata, c1_wdata;
    logic [31:0] c0_rdata, c1_rdata;
    logic        c0_done, c1_done;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_c0_rdata, exp_c1_rdata;

    rip_mem_port_arbiter_if #(.ADDR_WIDTH(32), .LINE_SIZE(4)) bus ();

    rip_mem_port_arbiter #(.ADDR_WIDTH(32), .LINE_SIZE(4)) dut (
        .clk(clk), .rstn(rstn),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_rdata(c0_rdata), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_done(c1_done),
        .mst(bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [167:0] all_outs();
        return {bus.waddr, bus.wdata, bus.wstrb, bus.wvalid, bus.raddr, bus.rvalid,
                c0_rdata, c0_done, c1_rdata, c1_done};
    endfunction

    task automatic test_reset;
        rstn = 1'b0;
        c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
        c0_addr = 0; c1_addr = 0; c0_wdata = 0; c1_wdata = 0;
        bus.wready = 0; bus.wdone = 0; bus.rready = 0; bus.rdone = 0; bus.rdata = 0;
        tick(); tick();
        n_cmp++; if (all_outs() !== 168'd0) begin n_bad++; $display("FAIL reset_outs got %0h want 0", all_outs()); end
        rstn = 1'b1;
        tick();
        n_cmp++; if (all_outs() !== 168'd0) begin n_bad++; $display("FAIL idle_outs got %0h want 0", all_outs()); end
        exp_c0_rdata = 32'h0; exp_c1_rdata = 32'h0;
    endtask

    task automatic test_single_read;
        c0_req = 1; c0_we = 4'b0000; c0_addr = 32'h100; bus.rready = 1;
        tick();
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.raddr !== 32'h100) begin n_bad++; $display("FAIL rd_issue got rvalid=%0b raddr=%0h want 1/100", bus.rvalid, bus.raddr); end
        n_cmp++; if (bus.wvalid !== 1'b0) begin n_bad++; $display("FAIL rd_no_wvalid got %0b want 0", bus.wvalid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.rvalid !== 1'b0 || c0_done !== 1'b0) begin n_bad++; $display("FAIL rd_wait%0d got rvalid=%0b done=%0b want 0/0", i, bus.rvalid, c0_done); end
        end
        bus.rdone = 1; bus.rdata = 32'hDEADBEEF;
        tick();
        bus.rdone = 0; c0_req = 0;
        exp_c0_rdata = 32'hDEADBEEF;
        n_cmp++; if (c0_done !== 1'b1 || c0_rdata !== exp_c0_rdata) begin n_bad++; $display("FAIL rd_resp got done=%0b rdata=%0h want 1/deadbeef", c0_done, c0_rdata); end
        n_cmp++; if (c1_done !== 1'b0) begin n_bad++; $display("FAIL rd_c1_done got %0b want 0", c1_done); end
        tick();
        n_cmp++; if (c0_done !== 1'b0 || c0_rdata !== exp_c0_rdata) begin n_bad++; $display("FAIL rd_after got done=%0b rdata=%0h want 0/deadbeef", c0_done, c0_rdata); end
        tick();
        n_cmp++; if (bus.rvalid !== 1'b0 || c0_done !== 1'b0) begin n_bad++; $display("FAIL rd_idle got rvalid=%0b done=%0b want 0/0", bus.rvalid, c0_done); end
        bus.rready = 0;
    endtask

    task automatic test_write_backpressure;
        c1_req = 1; c1_we = 4'b0011; c1_addr = 32'h200; c1_wdata = 32'h12345678; bus.wready = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bus.wvalid !== 1'b1 || bus.waddr !== 32'h200 || bus.wdata !== 32'h12345678 || bus.wstrb !== 4'b0011)
                begin n_bad++; $display("FAIL wr_hold%0d got v=%0b a=%0h d=%0h s=%0h want 1/200/12345678/3", i, bus.wvalid, bus.waddr, bus.wdata, bus.wstrb); end
            if (i == 5) bus.wready = 1;
            tick();
        end
        bus.wready = 0;
        n_cmp++; if (bus.wvalid !== 1'b0 || bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_accept got wvalid=%0b rvalid=%0b want 0/0", bus.wvalid, bus.rvalid); end
        tick();
        n_cmp++; if (c1_done !== 1'b0) begin n_bad++; $display("FAIL wr_early_done got %0b want 0", c1_done); end
        bus.wdone = 1;
        tick();
        bus.wdone = 0; c1_req = 0;
        n_cmp++; if (c1_done !== 1'b1 || c0_done !== 1'b0) begin n_bad++; $display("FAIL wr_resp got c1=%0b c0=%0b want 1/0", c1_done, c0_done); end
        n_cmp++; if (c1_rdata !== exp_c1_rdata) begin n_bad++; $display("FAIL wr_rdata got %0h want %0h", c1_rdata, exp_c1_rdata); end
        tick();
        n_cmp++; if (c1_done !== 1'b0) begin n_bad++; $display("FAIL wr_pulse got %0b want 0", c1_done); end
        tick();
    endtask

    task automatic test_arbitration;
`ifdef RIP_MEM_ARB_FIXED_PRIO_EN
        logic exp_gnt [3] = '{1'b0, 1'b1, 1'b0};
        int   ntx = 3;
`else
        logic exp_gnt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int   ntx = 4;
`endif
        logic [31:0] exp_addr;
        c0_req = 1; c1_req = 1; c0_we = 0; c1_we = 0; c0_addr = 32'hA0; c1_addr = 32'hB0; bus.rready = 1;
        for (int i = 0; i < ntx; i++) begin
            exp_addr = exp_gnt[i] ? 32'hB0 : 32'hA0;
            tick();
            n_cmp++; if (bus.rvalid !== 1'b1 || bus.raddr !== exp_addr) begin n_bad++; $display("FAIL arb_grant%0d got rvalid=%0b raddr=%0h want 1/%0h", i, bus.rvalid, bus.raddr, exp_addr); end
            tick();
            bus.rdone = 1; bus.rdata = 32'h10000000 + i;
            tick();
            bus.rdone = 0;
            if (exp_gnt[i]) exp_c1_rdata = 32'h10000000 + i;
            else            exp_c0_rdata = 32'h10000000 + i;
            n_cmp++; if (c0_done !== !exp_gnt[i] || c1_done !== exp_gnt[i]) begin n_bad++; $display("FAIL arb_done%0d got c0=%0b c1=%0b want %0b/%0b", i, c0_done, c1_done, !exp_gnt[i], exp_gnt[i]); end
            n_cmp++; if (c0_rdata !== exp_c0_rdata || c1_rdata !== exp_c1_rdata) begin n_bad++; $display("FAIL arb_rdata%0d got %0h/%0h want %0h/%0h", i, c0_rdata, c1_rdata, exp_c0_rdata, exp_c1_rdata); end
`ifdef RIP_MEM_ARB_FIXED_PRIO_EN
            if (i == 0) c0_req = 0;
            if (i == 1) begin c0_req = 1; c1_req = 0; end
`endif
            if (i == ntx - 1) begin c0_req = 0; c1_req = 0; end
            tick();
        end
        tick();
        bus.rready = 0;
    endtask

    task automatic test_stray_done;
        bus.rdone = 1; bus.wdone = 1; bus.rdata = 32'h77777777;
        tick();
        bus.rdone = 0; bus.wdone = 0;
        n_cmp++; if (c0_done !== 1'b0 || c1_done !== 1'b0 || bus.rvalid !== 1'b0 || bus.wvalid !== 1'b0) begin n_bad++; $display("FAIL stray_idle got c0=%0b c1=%0b rv=%0b wv=%0b want 0", c0_done, c1_done, bus.rvalid, bus.wvalid); end
        n_cmp++; if (c0_rdata !== exp_c0_rdata) begin n_bad++; $display("FAIL stray_idle_rdata got %0h want %0h", c0_rdata, exp_c0_rdata); end
        c0_req = 1; c0_we = 0; c0_addr = 32'h300; bus.rready = 1;
        tick();
        tick();
        bus.wdone = 1; bus.rdata = 32'h55555555;
        tick();
        bus.wdone = 0;
        n_cmp++; if (c0_done !== 1'b0 || c0_rdata !== exp_c0_rdata) begin n_bad++; $display("FAIL stray_wdone got done=%0b rdata=%0h want 0/%0h", c0_done, c0_rdata, exp_c0_rdata); end
        tick();
        n_cmp++; if (c0_done !== 1'b0) begin n_bad++; $display("FAIL stray_still_wait got %0b want 0", c0_done); end
        bus.rdone = 1; bus.rdata = 32'hCAFEF00D;
        tick();
        bus.rdone = 0; c0_req = 0;
        exp_c0_rdata = 32'hCAFEF00D;
        n_cmp++; if (c0_done !== 1'b1 || c0_rdata !== exp_c0_rdata) begin n_bad++; $display("FAIL stray_resp got done=%0b rdata=%0h want 1/cafef00d", c0_done, c0_rdata); end
        tick();
        tick();
        bus.rready = 0;
    endtask

    task automatic test_reset_mid_op;
        c0_req = 1; c0_we = 0; c0_addr = 32'h400; bus.rready = 1;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (all_outs() !== 168'd0) begin n_bad++; $display("FAIL midrst_outs got %0h want 0", all_outs()); end
        c0_req = 0;
        tick(); tick();
        #3 rstn = 1'b1;
        c0_req = 1; c1_req = 1; c0_addr = 32'hA0; c1_addr = 32'hB0; c0_we = 0; c1_we = 0;
        tick();
        n_cmp++; if (bus.rvalid !== 1'b1 || bus.raddr !== 32'hA0) begin n_bad++; $display("FAIL midrst_tie got rvalid=%0b raddr=%0h want 1/a0", bus.rvalid, bus.raddr); end
        tick();
        bus.rdone = 1; bus.rdata = 32'h0BADF00D;
        tick();
        bus.rdone = 0; c0_req = 0; c1_req = 0;
        n_cmp++; if (c0_done !== 1'b1 || c1_done !== 1'b0 || c0_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL midrst_resp got c0=%0b c1=%0b rdata=%0h want 1/0/badf00d", c0_done, c1_done, c0_rdata); end
        tick();
        bus.rready = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_backpressure();
        test_arbitration();
        test_stray_done();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
